reg4_serializer: RTL and testbench



---
 rtl/reg4_serializer.sv | 103 ++++++++++
 tb/tb_reg4_serializer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/reg4_serializer.sv
// Parallel-in/serial-out stage: one WIDTH-bit word per handshake, one bit per accepted serial beat.
// Optional REG4_SERIALIZER_PARITY_EN appends an even-parity beat to every word.
module reg4_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  input  logic             ser_ready,
  output logic             busy
);

`ifdef REG4_SERIALIZER_PARITY_EN
  localparam int NBEATS = WIDTH + 1;
`else
  localparam int NBEATS = WIDTH;
`endif
  localparam int CW = $clog2(NBEATS);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef REG4_SERIALIZER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic last_beat;
  logic beat_acc;
  logic load;
  logic data_bit;

  always_comb begin
    last_beat = (state_q == SHIFT) && (cnt_q == CW'(NBEATS - 1));
    beat_acc  = (state_q == SHIFT) && ser_ready;
    // A last-beat accept reopens the input so the next word follows with no bubble.
    in_ready  = !reset && ((state_q == IDLE) || (beat_acc && last_beat));
    load      = in_ready && in_valid;

    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
`ifdef REG4_SERIALIZER_PARITY_EN
    parity_d = parity_q;
`endif

    if (load) begin
      state_d  = SHIFT;
      shreg_d  = in_data;
      cnt_d    = '0;
`ifdef REG4_SERIALIZER_PARITY_EN
      parity_d = ^in_data;
`endif
    end else if (beat_acc) begin
      if (last_beat) begin
        state_d = IDLE;
      end else begin
        if (MSB_FIRST) shreg_d = shreg_q << 1;
        else           shreg_d = shreg_q >> 1;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    if (MSB_FIRST) data_bit = shreg_q[WIDTH-1];
    else           data_bit = shreg_q[0];
`ifdef REG4_SERIALIZER_PARITY_EN
    // The final beat of a word carries the parity captured at load.
    if (last_beat) data_bit = parity_q;
`endif
    ser_valid = (state_q == SHIFT);
    busy      = (state_q == SHIFT);
    ser_last  = last_beat;
    ser_out   = ser_valid && data_bit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
`ifdef REG4_SERIALIZER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
`ifdef REG4_SERIALIZER_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_reg4_serializer.sv
// Directed bench for reg4_serializer: LSB-first and MSB-first instances share stimulus.
module tb_reg4_serializer;

`ifdef REG4_SERIALIZER_PARITY_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in_data;
  logic       in_valid;
  logic       ser_ready;

  logic in_ready_l, ser_out_l, ser_valid_l, ser_last_l, busy_l;
  logic in_ready_m, ser_out_m, ser_valid_m, ser_last_m, busy_m;

  int tests  = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg4_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_l), .ser_out(ser_out_l), .ser_valid(ser_valid_l),
    .ser_last(ser_last_l), .ser_ready(ser_ready), .busy(busy_l)
  );

  reg4_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_m), .ser_out(ser_out_m), .ser_valid(ser_valid_m),
    .ser_last(ser_last_m), .ser_ready(ser_ready), .busy(busy_m)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  // exp_l/exp_m hold the expected bit of beat i at position i (beat 0 = bit 0).
  task automatic send_words(input int nwords, input logic [3:0] w0, input logic [3:0] w1,
                            input logic [31:0] exp_l, input logic [31:0] exp_m,
                            input int stall_beat);
    in_data   = w0;
    in_valid  = 1'b1;
    ser_ready = 1'b1;
    #1;
    chk("idle_in_ready", in_ready_l, 1);
    for (int i = 0; i < nwords * NB; i++) begin
      @(posedge clk); #1;
      if (i % NB == 0) begin
        if (i / NB + 1 < nwords) begin
          in_data = w1;
        end else begin
          in_valid = 1'b0;
          in_data  = ~in_data;
        end
      end
      #1;
      chk("beat_valid", ser_valid_l, 1);
      chk("beat_busy",  busy_l, 1);
      chk("beat_out",   ser_out_l, exp_l[i]);
      chk("beat_out_msb", ser_out_m, exp_m[i]);
      chk("beat_last",  ser_last_l, (i % NB == NB - 1) ? 1 : 0);
      chk("beat_in_ready", in_ready_l, (i % NB == NB - 1) ? 1 : 0);
      if (i == stall_beat) begin
        ser_ready = 1'b0;
        repeat (3) begin
          @(posedge clk); #2;
          chk("stall_out",  ser_out_l, exp_l[i]);
          chk("stall_last", ser_last_l, 0);
          chk("stall_in_ready", in_ready_l, 0);
          chk("stall_valid", ser_valid_l, 1);
        end
        ser_ready = 1'b1;
      end
    end
    @(posedge clk); #2;
    chk("end_valid", ser_valid_l, 0);
    chk("end_busy",  busy_l, 0);
    chk("end_valid_msb", ser_valid_m, 0);
    chk("end_in_ready", in_ready_l, 1);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    ser_ready = 1'b1;
    in_data   = 4'b0000;
    #2;
    chk("rst_in_ready", in_ready_l, 0);
    chk("rst_valid",    ser_valid_l, 0);
    chk("rst_out",      ser_out_l, 0);
    chk("rst_busy",     busy_l, 0);
    chk("rst_last",     ser_last_l, 0);
    #13 reset = 1'b0;
    #2;
    chk("post_rst_in_ready", in_ready_l, 1);
    chk("post_rst_valid",    ser_valid_l, 0);
    chk("post_rst_out",      ser_out_l, 0);
    chk("post_rst_busy",     busy_l, 0);

`ifdef REG4_SERIALIZER_PARITY_EN
    send_words(1, 4'b0010, 4'b0000, 32'b1_0010, 32'b1_0100, -1);
    send_words(2, 4'b1011, 4'b0100, 32'b10100_11011, 32'b10010_11101, -1);
    send_words(1, 4'b0110, 4'b0000, 32'b0_0110, 32'b0_0110, 1);
`else
    send_words(1, 4'b0010, 4'b0000, 32'b0010, 32'b0100, -1);
    send_words(2, 4'b1011, 4'b0100, 32'b0100_1011, 32'b0010_1101, -1);
    send_words(1, 4'b0110, 4'b0000, 32'b0110, 32'b0110, 1);
`endif

    // Reset in the middle of a word.
    in_data  = 4'b1111;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_pre_rst_out", ser_out_l, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid",    ser_valid_l, 0);
    chk("mid_rst_out",      ser_out_l, 0);
    chk("mid_rst_busy",     busy_l, 0);
    chk("mid_rst_in_ready", in_ready_l, 0);
    @(posedge clk); #2 reset = 1'b0;
    @(posedge clk); #1;
    chk("after_rst_valid", ser_valid_l, 0);
`ifdef REG4_SERIALIZER_PARITY_EN
    send_words(1, 4'b0001, 4'b0000, 32'b1_0001, 32'b1_1000, -1);
    send_words(1, 4'b0111, 4'b0000, 32'b1_0111, 32'b1_1110, -1);
    send_words(1, 4'b0011, 4'b0000, 32'b0_0011, 32'b0_1100, -1);
`else
    send_words(1, 4'b0001, 4'b0000, 32'b0001, 32'b1000, -1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
